// File: rtl/tdm_pkg.sv
// TDM link shared definitions: FSM encoding and lane geometry.
// Used by the receive-side demux and the transmit-side mux.
package tdm_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  localparam int TDM_LANES = 4;

  function automatic int sel_w(input int lanes);
    return $clog2(lanes);
  endfunction

  localparam int TDM_SEL_W = sel_w(TDM_LANES);

endpackage

// File: rtl/tdm_lane_reg.sv
// One lane of the demux: W-bit register with sync clear
// and load enable.
module tdm_lane_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)
      q <= '0;
    else if (load)
      q <= d;
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: gathers LANES slot samples into a
// parallel frame offered under valid/ready.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int W     = 1,
  parameter int LANES = TDM_LANES,
  parameter int SEL_W = $clog2(LANES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [W-1:0]       din,
  input  logic               din_valid,
  input  logic               din_sof,
  output logic               din_ready,
  output logic [LANES*W-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [SEL_W-1:0]   slot,
  output logic               sync_err
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  state_t           state;
  logic             accept;
  logic             xfer;
  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;

  assign din_ready = (state == ST_HOLD) ? dout_ready : 1'b1;
  assign accept    = din_valid & din_ready;
  assign xfer      = dout_valid & dout_ready;

  // sof always lands in lane 0; plain samples only store while collecting
  assign wr_en  = accept & (din_sof | (state == ST_COLLECT));
  assign wr_sel = din_sof ? '0 : slot;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    tdm_lane_reg #(
      .W(W)
    ) u_lane (
      .clk (clk),
      .rst (rst),
      .load(wr_en && (wr_sel == SEL_W'(k))),
      .d   (din),
      .q   (dout[k*W +: W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HUNT;
      slot       <= '0;
      dout_valid <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      unique case (state)
        ST_HUNT: begin
          if (accept && din_sof) begin
            slot  <= ONE;
            state <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (accept) begin
            if (din_sof) begin
              sync_err <= 1'b1;
              slot     <= ONE;
            end else if (slot == LAST) begin
              slot       <= '0;
              dout_valid <= 1'b1;
              state      <= ST_HOLD;
            end else begin
              slot <= slot + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (xfer) begin
            dout_valid <= 1'b0;
            if (accept && din_sof) begin
              slot  <= ONE;
              state <= ST_COLLECT;
            end else begin
              state <= ST_HUNT;
              if (accept)
                sync_err <= 1'b1;
            end
          end
        end
        default: state <= ST_HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux with W=4, LANES=4.
// Directed frames; a negedge monitor checks every transfer.
module tb_tdm_demux;

  localparam int W     = 4;
  localparam int LANES = 4;
  localparam int SEL_W = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [W-1:0]       din = '0;
  logic               din_valid = 1'b0;
  logic               din_sof = 1'b0;
  logic               din_ready;
  logic [LANES*W-1:0] dout;
  logic               dout_valid;
  logic               dout_ready = 1'b0;
  logic [SEL_W-1:0]   slot;
  logic               sync_err;

  int n_cmp   = 0;
  int n_err   = 0;
  int se_seen = 0;
  logic [15:0] exp_q[$];

  tdm_demux #(
    .W(W),
    .LANES(LANES),
    .SEL_W(SEL_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_sof   (din_sof),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .slot      (slot),
    .sync_err  (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic s);
    int   n;
    logic rdy;
    n = 0;
    din = d;
    din_sof = s;
    din_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = din_ready;
      tick();
      n++;
    end while (!rdy && n < 20);
    if (!rdy) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got no accept want accept");
    end
    din_valid = 1'b0;
    din_sof = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && sync_err) se_seen++;
    if (!rst && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL frame_unexpected: got %0h want none", dout);
      end else begin
        chk("frame", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(dout_valid), 0);
    chk("rst_slot", 32'(slot), 0);
    chk("rst_err", 32'(sync_err), 0);
    chk("rst_ready", 32'(din_ready), 1);
    rst = 1'b0;

    send(4'h5, 0); send(4'h6, 0); send(4'h7, 0);
    chk("hunt_valid", 32'(dout_valid), 0);
    chk("hunt_slot", 32'(slot), 0);
    chk("hunt_dout", 32'(dout), 0);
    chk("hunt_err", 32'(se_seen), 0);

    exp_q.push_back(16'hDCBA);
    send(4'hA, 1); send(4'hB, 0); send(4'hC, 0);
    chk("f1_slot3", 32'(slot), 3);
    chk("f1_pre_valid", 32'(dout_valid), 0);
    send(4'hD, 0);
    chk("f1_valid", 32'(dout_valid), 1);
    chk("f1_dout", 32'(dout), 32'hDCBA);
    chk("f1_slot0", 32'(slot), 0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    chk("f1_drained", 32'(dout_valid), 0);

    exp_q.push_back(16'hDCBA);
    send(4'hA, 1); send(4'hB, 0);
    repeat (3) tick();
    chk("gap_slot", 32'(slot), 2);
    chk("gap_valid_lo", 32'(dout_valid), 0);
    send(4'hC, 0); send(4'hD, 0);
    chk("gap_valid", 32'(dout_valid), 1);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;

    exp_q.push_back(16'h6789);
    exp_q.push_back(16'h4321);
    send(4'h9, 1); send(4'h8, 0); send(4'h7, 0); send(4'h6, 0);
    din = 4'h1;
    din_sof = 1'b1;
    din_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_ready", 32'(din_ready), 0);
      chk("bp_dout", 32'(dout), 32'h6789);
    end
    tick();
    dout_ready = 1'b1;
    tick();
    din_valid = 1'b0;
    din_sof = 1'b0;
    chk("bb_valid", 32'(dout_valid), 0);
    chk("bb_slot", 32'(slot), 1);
    chk("bb_lane0", 32'(dout), 32'h6781);
    send(4'h2, 0); send(4'h3, 0); send(4'h4, 0);
    chk("bb_dout", 32'(dout), 32'h4321);
    tick();
    dout_ready = 1'b0;
    chk("bb_done", 32'(dout_valid), 0);

    exp_q.push_back(16'hA987);
    send(4'h1, 1); send(4'h2, 0); send(4'h7, 1);
    chk("err_pulse", 32'(sync_err), 1);
    chk("err_slot", 32'(slot), 1);
    send(4'h8, 0);
    chk("err_once", 32'(sync_err), 0);
    send(4'h9, 0); send(4'hA, 0);
    chk("err_valid", 32'(dout_valid), 1);
    chk("err_dout", 32'(dout), 32'hA987);
    dout_ready = 1'b1;
    send(4'hF, 0);
    dout_ready = 1'b0;
    chk("drop_err", 32'(sync_err), 1);
    chk("drop_valid", 32'(dout_valid), 0);
    chk("drop_dout", 32'(dout), 32'hA987);

    send(4'h1, 1); send(4'h2, 0); send(4'h3, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_dout", 32'(dout), 0);
    chk("mid_rst_valid", 32'(dout_valid), 0);
    chk("mid_rst_slot", 32'(slot), 0);
    send(4'h5, 0);
    chk("mid_rst_hunt", 32'(slot), 0);
    send(4'hE, 1); send(4'hD, 0); send(4'hC, 0); send(4'hB, 0);
    chk("hold_pre", 32'(dout), 32'hBCDE);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hold_rst_valid", 32'(dout_valid), 0);
    chk("hold_rst_dout", 32'(dout), 0);
    chk("hold_rst_slot", 32'(slot), 0);
    chk("hold_rst_ready", 32'(din_ready), 1);

    exp_q.push_back(16'h1234);
    send(4'h4, 1); send(4'h3, 0); send(4'h2, 0); send(4'h1, 0);
    dout_ready = 1'b1;
    tick();
    dout_ready = 1'b0;
    repeat (3) tick();
    chk("q_empty", 32'(exp_q.size()), 0);
    chk("err_count", 32'(se_seen), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
